// File: rtl/gayle_sector_fifo.sv
// gayle_sector_fifo: sector-counting word FIFO between the Gayle CPU register port and the IDE transfer engine
module gayle_sector_fifo #(
  parameter int DW = 16,
  parameter int AW = 12,
  parameter int SW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clk7_en,
  input  logic          flush,
  input  logic [DW-1:0] data_in,
  input  logic          wr,
  input  logic          rd,
  output logic [DW-1:0] data_out,
  output logic          empty,
  output logic          full,
  output logic          sect_avail,
  output logic [AW-SW:0] sect_cnt,
  output logic [AW:0]   level,
  output logic          last_in,
  output logic          last_out,
  output logic          ovf,
  output logic          unf
);
  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};
  logic [DW-1:0] mem [0:2**AW-1];
  logic [AW:0]   inptr, outptr;
  logic          empty_d, wr_acc, rd_acc;
  assign full       = level == DEPTH;
  assign wr_acc     = wr & ~full;
  assign rd_acc     = rd & (level != '0);
  assign empty      = (level == '0) | empty_d;
  assign sect_cnt   = inptr[AW:SW] - outptr[AW:SW];
  assign sect_avail = sect_cnt != '0;
  assign last_in    = &inptr[SW-1:0];
  assign last_out   = &outptr[SW-1:0];
  // pointers, level, sticky errors and the registered read port; flush keeps data_out
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      inptr    <= '0;
      outptr   <= '0;
      level    <= '0;
      ovf      <= 1'b0;
      unf      <= 1'b0;
      empty_d  <= 1'b1;
      data_out <= '0;
    end else if (clk7_en) begin
      if (flush) begin
        inptr   <= '0;
        outptr  <= '0;
        level   <= '0;
        ovf     <= 1'b0;
        unf     <= 1'b0;
        empty_d <= 1'b1;
      end else begin
        inptr    <= inptr + (AW+1)'(wr_acc);
        outptr   <= outptr + (AW+1)'(rd_acc);
        level    <= level + (AW+1)'(wr_acc) - (AW+1)'(rd_acc);
        ovf      <= ovf | (wr & full);
        unf      <= unf | (rd & (level == '0));
        empty_d  <= level == '0;
        data_out <= mem[outptr[AW-1:0]];
      end
    end
  // storage array, written only by accepted writes and never cleared
  always_ff @(posedge clk)
    if (clk7_en & ~flush & wr_acc) mem[inptr[AW-1:0]] <= data_in;
endmodule

// File: tb/tb_gayle_sector_fifo.sv
// tb_gayle_sector_fifo: vector table, directed sector/full/flush/reset sequences and randomized traffic against a queue model
module tb_gayle_sector_fifo;
  logic clk = 0, reset = 0, clk7_en = 0, flush = 0, wr = 0, rd = 0;
  logic [15:0] data_in = 0;
  logic [15:0] data_out;
  logic empty, full, sect_avail, last_in, last_out, ovf, unf;
  logic [4:0] sect_cnt;
  logic [12:0] level;

  gayle_sector_fifo dut (
    .clk(clk), .reset(reset), .clk7_en(clk7_en), .flush(flush), .data_in(data_in),
    .wr(wr), .rd(rd), .data_out(data_out), .empty(empty), .full(full),
    .sect_avail(sect_avail), .sect_cnt(sect_cnt), .level(level),
    .last_in(last_in), .last_out(last_out), .ovf(ovf), .unf(unf)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  logic [15:0] q[$];
  int wcnt, rcnt;
  bit m_ovf, m_unf, m_ed, m_dv;
  logic [15:0] m_dout;

  typedef struct {
    bit fl, w, r;
    logic [15:0] d;
    int lv;
    bit e, o, u, cd;
    logic [15:0] dout;
  } vec_t;
  vec_t tv[9];

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  task automatic model_clear();
    q.delete();
    wcnt = 0;
    rcnt = 0;
    m_ovf = 0;
    m_unf = 0;
    m_ed = 1;
  endtask

  task automatic check_model();
    int lv;
    lv = q.size();
    check("level", int'(level), lv);
    check("empty", int'(empty), int'(lv == 0 || m_ed));
    check("full", int'(full), int'(lv == 4096));
    check("sect_cnt", int'(sect_cnt), (wcnt / 256 - rcnt / 256) % 32);
    check("sect_avail", int'(sect_avail), int'(wcnt / 256 != rcnt / 256));
    check("last_in", int'(last_in), int'(wcnt % 256 == 255));
    check("last_out", int'(last_out), int'(rcnt % 256 == 255));
    check("ovf", int'(ovf), int'(m_ovf));
    check("unf", int'(unf), int'(m_unf));
    if (m_dv) check("data_out", int'(data_out), int'(m_dout));
  endtask

  task automatic cyc(input bit en, input bit fl, input bit w, input bit r, input logic [15:0] d);
    int lv;
    bit wa, ra;
    clk7_en = en;
    flush = fl;
    wr = w;
    rd = r;
    data_in = d;
    @(posedge clk);
    if (en) begin
      if (fl) model_clear();
      else begin
        lv = q.size();
        wa = w && lv < 4096;
        ra = r && lv != 0;
        m_ed = lv == 0;
        m_dv = lv != 0;
        if (lv != 0) m_dout = q[0];
        if (ra) begin
          void'(q.pop_front());
          rcnt++;
        end
        if (wa) begin
          q.push_back(d);
          wcnt++;
        end
        m_ovf = m_ovf | (w && !wa);
        m_unf = m_unf | (r && !ra);
      end
    end
    #1;
    check_model();
  endtask

  task automatic wr_n(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 1, 0, 16'($urandom));
  endtask

  task automatic rd_n(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 1, 16'h0);
  endtask

  task automatic to_300_ovf();
    cyc(1, 1, 0, 0, 16'h0);
    wr_n(4096);
    cyc(1, 0, 1, 0, 16'hBEEF);
    rd_n(3796);
    check("mid_level", int'(level), 300);
    check("mid_ovf", int'(ovf), 1);
  endtask

  initial begin
    model_clear();
    m_dout = 0;
    m_dv = 1;
    clk7_en = 1;
    for (int i = 0; i < 4; i++) begin
      wr = i[0];
      rd = ~i[0];
      @(posedge clk);
      #1;
      check("rst_level", int'(level), 0);
      check("rst_empty", int'(empty), 1);
      check("rst_dout", int'(data_out), 0);
      check("rst_flags", int'({full, sect_avail, sect_cnt, last_in, last_out, ovf, unf}), 0);
    end
    check_model();
    reset = 1;
    for (int i = 0; i < 4; i++) begin
      cyc(1, 0, 0, 0, 16'h0);
      check("idle_level", int'(level), 0);
      check("idle_empty", int'(empty), 1);
    end

    tv[0] = '{0, 0, 0, 16'h0000, 0, 1, 0, 0, 0, 16'h0000};
    tv[1] = '{0, 0, 1, 16'h0000, 0, 1, 0, 1, 0, 16'h0000};
    tv[2] = '{0, 1, 0, 16'h1111, 1, 1, 0, 1, 0, 16'h0000};
    tv[3] = '{0, 0, 0, 16'h0000, 1, 0, 0, 1, 1, 16'h1111};
    tv[4] = '{0, 1, 1, 16'h2222, 1, 0, 0, 1, 1, 16'h1111};
    tv[5] = '{0, 0, 1, 16'h0000, 0, 1, 0, 1, 1, 16'h2222};
    tv[6] = '{0, 1, 1, 16'h3333, 1, 1, 0, 1, 0, 16'h0000};
    tv[7] = '{1, 1, 1, 16'h4444, 0, 1, 0, 0, 0, 16'h0000};
    tv[8] = '{0, 0, 0, 16'h0000, 0, 1, 0, 0, 1, 16'h1111};
    for (int i = 0; i < 9; i++) begin
      cyc(1, tv[i].fl, tv[i].w, tv[i].r, tv[i].d);
      check($sformatf("tv%0d_level", i), int'(level), tv[i].lv);
      check($sformatf("tv%0d_empty", i), int'(empty), int'(tv[i].e));
      check($sformatf("tv%0d_ovf", i), int'(ovf), int'(tv[i].o));
      check($sformatf("tv%0d_unf", i), int'(unf), int'(tv[i].u));
      if (tv[i].cd) check($sformatf("tv%0d_dout", i), int'(data_out), int'(tv[i].dout));
    end

    cyc(1, 0, 1, 0, 16'hA5A5);
    check("a5_level", int'(level), 1);
    check("a5_empty_1", int'(empty), 1);
    cyc(1, 0, 0, 0, 16'h0);
    check("a5_empty_2", int'(empty), 0);
    cyc(1, 0, 0, 1, 16'h0);
    check("a5_dout", int'(data_out), 16'hA5A5);
    check("a5_level0", int'(level), 0);
    check("a5_empty_rd", int'(empty), 1);

    cyc(1, 1, 0, 0, 16'h0);
    for (int i = 0; i < 256; i++) begin
      if (i == 255) check("last_in_w255", int'(last_in), 1);
      cyc(1, 0, 1, 0, 16'(i));
    end
    check("sec_avail", int'(sect_avail), 1);
    check("sec_cnt1", int'(sect_cnt), 1);
    for (int i = 0; i < 255; i++) begin
      cyc(1, 0, 0, 1, 16'h0);
      check("sec_hold", int'(sect_avail), 1);
      check("sec_data", int'(data_out), i);
    end
    check("last_out_r255", int'(last_out), 1);
    cyc(1, 0, 0, 1, 16'h0);
    check("sec_data255", int'(data_out), 255);
    check("sec_fall", int'(sect_avail), 0);

    wr_n(4096);
    check("fill_full", int'(full), 1);
    check("fill_sect", int'(sect_cnt), 16);
    cyc(1, 0, 1, 0, 16'hDEAD);
    check("ovf_set", int'(ovf), 1);
    check("ovf_level", int'(level), 4096);
    rd_n(4096);
    check("drain_empty", int'(empty), 1);
    cyc(1, 0, 0, 1, 16'h0);
    check("unf_set", int'(unf), 1);

    wr_n(10);
    for (int i = 0; i < 10000; i++) begin
      cyc(i % 2 == 0, 0, 1, 1, 16'($urandom));
      check("rw_level10", int'(level), 10);
    end

    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(3, 0) != 0, $urandom_range(199, 0) == 0,
          $urandom_range(9, 0) < (i < 1500 ? 7 : 3), $urandom_range(9, 0) < (i < 1500 ? 3 : 7),
          16'($urandom));

    to_300_ovf();
    cyc(1, 1, 1, 0, 16'h7777);
    check("fl_level", int'(level), 0);
    check("fl_ovf", int'(ovf), 0);
    check("fl_empty", int'(empty), 1);
    cyc(1, 0, 0, 0, 16'h0);
    check("fl_discard", int'(level), 0);

    to_300_ovf();
    #2;
    reset = 0;
    #1;
    check("ar_level", int'(level), 0);
    check("ar_ovf", int'(ovf), 0);
    check("ar_empty", int'(empty), 1);
    check("ar_sect", int'(sect_cnt), 0);
    check("ar_dout", int'(data_out), 0);
    model_clear();
    m_dout = 0;
    m_dv = 1;
    check_model();
    reset = 1;
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 16'h0);
    wr_n(5);
    rd_n(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/gayle_sector_fifo.md
Name: gayle_sector_fifo

Overview:
Parametrised sector-buffer FIFO for the Gayle IDE data path. It stores words between the CPU-side register interface and the drive-side transfer engine, and counts whole sectors so that DRQ/IRQ logic can handshake per sector. It adds the following:
- Configurable width, depth and sector size.
- Overflow and underflow protection with sticky error flags.
- Synchronous flush.
- Level and sector-count outputs.

Parameters:
DW, 16, data word width in bits
AW, 12, address width; depth = 2^AW words
SW, 8, sector address width; sector = 2^SW words; SW < AW required

Ports:
clk  in  1  bus clock
reset  in  1  asynchronous, active-low reset
clk7_en  in  1  clock enable; all synchronous state advances only when high
flush  in  1  synchronous clear of FIFO contents and error flags
data_in  in  DW  write data
wr  in  1  write request
rd  in  1  read request
data_out  out  DW  registered read data
empty  out  1  no readable word
full  out  1  FIFO holds 2^AW words
sect_avail  out  1  at least one complete sector buffered
sect_cnt  out  AW-SW+1  number of complete sectors buffered
level  out  AW+1  words buffered, 0..2^AW
last_in  out  1  next accepted write is the last word of a sector
last_out  out  1  next accepted read is the last word of a sector
ovf  out  1  sticky: write attempted while full
unf  out  1  sticky: read attempted while empty

Behaviour:
- Clock and reset: one clock, `clk`. `reset` is asynchronous and active-low. While `reset` is low:
  - `inptr` = `outptr` = 0, `level` = 0, `ovf` = `unf` = 0.
  - `empty` = 1, `empty_d` = 1, `data_out` = 0.
  - `full` = 0, `sect_avail` = 0, `sect_cnt` = 0.
  - `last_in` = `last_out` = 0 (pointer low bits are 0).
- Gating: on cycles with `clk7_en` = 0, no register changes (pointers, `level`, flags, `data_out`, RAM).
- Pointers: `inptr` and `outptr` are AW+1 bits wide, wrap modulo 2^(AW+1). RAM is indexed by pointer bits [AW-1:0].
- Accept rules, evaluated on `clk7_en` cycles:
  - wr_acc = wr & ~full
  - rd_acc = rd & (level != 0)
  - A write while full is dropped and sets `ovf`. A read while level = 0 is dropped and sets `unf`.
  - Simultaneous wr and rd, both accepted: both pointers advance and `level` is unchanged.
  - Simultaneous wr and rd while full: the read is accepted, the write is rejected (`ovf` set).
  - Simultaneous wr and rd while level = 0: the write is accepted, the read is rejected (`unf` set).
- Level: `level` = inptr − outptr, held as a register updated by +1, −1 or 0. `full` = (level == 2^AW).
- RAM: on wr_acc, mem[inptr] <= data_in. Every `clk7_en` cycle, data_out <= mem[outptr] (one-cycle registered read). Read-during-write to the same address returns the old data; the empty delay covers this.
- Empty: empty_d <= (level == 0) each `clk7_en` cycle, and empty = (level == 0) | empty_d.
  - A write into an empty FIFO clears `empty` two enabled cycles after the write cycle.
  - Reading the last word sets `empty` in the same cycle that `level` reaches 0.
- Sectors:
  - sect_cnt = inptr[AW:SW] − outptr[AW:SW], modulo 2^(AW−SW+1).
  - sect_avail = (sect_cnt != 0). It rises when the last word of a sector is written and falls when the last word of that sector is read (hysteresis).
- Sector-boundary flags:
  - last_in = (inptr[SW-1:0] == all ones)
  - last_out = (outptr[SW-1:0] == all ones)
- Flush: on `clk7_en` and `flush`, the block returns to the reset state, except that `data_out` and the RAM contents are retained. Flush has priority over wr and rd in the same cycle; those requests are ignored and set no flags.
- Reset mid-transfer: partially written sectors are discarded. No clock is required for reset to take effect.

Test Plan:
- Reset low with wr/rd toggling → all outputs at their reset values. Release reset, idle 4 cycles → outputs unchanged.
- Single write 0xA5A5 to the empty FIFO (default parameters):
  - `level` = 1 after the edge, `empty` clears two enabled cycles later.
  - Assert rd → `data_out` = 0xA5A5 on the following edge, `level` = 0, `empty` = 1 the same cycle.
- Write 256 words 0..255:
  - `last_in` = 1 while writing word 255.
  - `sect_avail` = 1 and `sect_cnt` = 1 after that write.
  - Read 255 words → `sect_avail` stays 1. 256th read with `last_out` = 1 → `sect_avail` = 0.
- Fill to 4096 words → `full` = 1, `sect_cnt` = 16. Extra write 0xDEAD → ignored, `ovf` = 1, `level` = 4096. Drain all 4096 → data in order. Extra read → `unf` = 1.
- Simultaneous rd+wr at level 10 for 5000 cycles, including pointer wrap past 8191:
  - `level` stays 10 and data order is preserved.
  - `clk7_en` low every other cycle → state frozen on disabled cycles.
- Mid-transfer (level 300, `ovf` = 1):
  - Flush with concurrent wr → `level` = 0, `ovf` = 0, `empty` = 1, write discarded.
  - Repeat with asynchronous reset pulsed between edges → immediate clear.
